bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// CPU/DMA shared memory bus arbiter: CPU wins ties, DMA bursts are capped at BURST_MAX cycles.
// Define ARB_FAIRNESS_EN to force a DMA turn after STARVE_LIMIT CPU cycles with DMA pending.
module bus_arbiter #(
  parameter int unsigned BURST_MAX    = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [15:0] cpu_address,
  input  logic        cpu_read_write,
  input  logic [7:0]  cpu_data_write,
  output logic        cpu_grant,
  input  logic        dma_req,
  input  logic [15:0] dma_address,
  input  logic        dma_read_write,
  input  logic [7:0]  dma_data_write,
  output logic        dma_grant,
  output logic [15:0] mem_address,
  output logic        mem_read_write,
  output logic [7:0]  mem_data_write,
  input  logic [7:0]  mem_data_read,
  output logic [7:0]  data_read
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    DMA_OWN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             cpu_grant_q, cpu_grant_d;
  logic             dma_grant_q, dma_grant_d;
  logic             starve_hit_c;
  logic             burst_at_limit_c;

  // burst_q holds completed DMA cycles, so the current cycle is the last when it equals BURST_MAX-1
  assign burst_at_limit_c = (burst_q >= BURST_MAX_C - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_req)      state_d = CPU_OWN;
        else if (dma_req) state_d = DMA_OWN;
      end
      CPU_OWN: begin
        if (!cpu_req)          state_d = dma_req ? DMA_OWN : IDLE;
        else if (starve_hit_c) state_d = DMA_OWN;
      end
      DMA_OWN: begin
        if (!dma_req)                          state_d = cpu_req ? CPU_OWN : IDLE;
        else if (cpu_req && burst_at_limit_c)  state_d = CPU_OWN;
      end
      default: state_d = IDLE;
    endcase

    burst_d = '0;
    if ((state_q == DMA_OWN) && (state_d == DMA_OWN)) begin
      burst_d = (burst_q == BURST_MAX_C) ? burst_q : burst_q + CNT_W'(1);
    end

    cpu_grant_d = (state_d == CPU_OWN);
    dma_grant_d = (state_d == DMA_OWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      cpu_grant_q <= 1'b0;
      dma_grant_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      cpu_grant_q <= cpu_grant_d;
      dma_grant_q <= dma_grant_d;
    end
  end

`ifdef ARB_FAIRNESS_EN
  localparam logic [CNT_W-1:0] STARVE_LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign starve_hit_c = dma_req && (starve_q >= STARVE_LIMIT_C - CNT_W'(1));

  always_comb begin
    starve_d = '0;
    if ((state_q == CPU_OWN) && (state_d == CPU_OWN) && dma_req) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  logic unused_starve_limit;

  assign starve_hit_c        = 1'b0;
  assign unused_starve_limit = ^(CNT_W'(STARVE_LIMIT));
`endif

  // Shared bus follows the registered owner, so fields switch together at edges only
  always_comb begin
    mem_address    = 16'h0000;
    mem_read_write = 1'b1;
    mem_data_write = 8'h00;
    case (state_q)
      CPU_OWN: begin
        mem_address    = cpu_address;
        mem_read_write = cpu_read_write;
        mem_data_write = cpu_data_write;
      end
      DMA_OWN: begin
        mem_address    = dma_address;
        mem_read_write = dma_read_write;
        mem_data_write = dma_data_write;
      end
      default: ;
    endcase
  end

  assign cpu_grant = cpu_grant_q;
  assign dma_grant = dma_grant_q;
  assign data_read = mem_data_read;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic vs an owner/run-length model.
module tb_bus_arbiter;

  localparam int BURST_MAX    = 8;
  localparam int STARVE_LIMIT = 4;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_address = 16'h0000;
  logic        cpu_read_write = 1'b1;
  logic [7:0]  cpu_data_write = 8'h00;
  logic        cpu_grant;
  logic        dma_req = 1'b0;
  logic [15:0] dma_address = 16'h0000;
  logic        dma_read_write = 1'b1;
  logic [7:0]  dma_data_write = 8'h00;
  logic        dma_grant;
  logic [15:0] mem_address;
  logic        mem_read_write;
  logic [7:0]  mem_data_write;
  logic [7:0]  mem_data_read = 8'h5A;
  logic [7:0]  data_read;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // model: who owns the bus, how long DMA has held it, how long CPU held it with DMA waiting
  int owner      = 0;
  int dma_run    = 0;
  int starve_run = 0;

  logic [15:0] ea;
  logic        er;
  logic [7:0]  ed;

  bus_arbiter #(.BURST_MAX(BURST_MAX), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_read_write(cpu_read_write),
    .cpu_data_write(cpu_data_write), .cpu_grant(cpu_grant),
    .dma_req(dma_req), .dma_address(dma_address), .dma_read_write(dma_read_write),
    .dma_data_write(dma_data_write), .dma_grant(dma_grant),
    .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_data_write(mem_data_write), .mem_data_read(mem_data_read), .data_read(data_read)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    int nxt;
    if (rst) begin
      owner = 0; dma_run = 0; starve_run = 0;
    end else begin
      case (owner)
        0: nxt = cpu_req ? 1 : (dma_req ? 2 : 0);
        1: begin
          if (!cpu_req) nxt = dma_req ? 2 : 0;
          else if (FAIR && dma_req && (starve_run + 1 >= STARVE_LIMIT)) nxt = 2;
          else nxt = 1;
        end
        default: begin
          if (!dma_req) nxt = cpu_req ? 1 : 0;
          else if (cpu_req && (dma_run >= BURST_MAX)) nxt = 1;
          else nxt = 2;
        end
      endcase
      starve_run = (owner == 1 && nxt == 1 && dma_req) ? starve_run + 1 : 0;
      dma_run    = (nxt == 2) ? ((owner == 2) ? dma_run + 1 : 1) : 0;
      owner      = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      case (owner)
        1:       begin ea = cpu_address; er = cpu_read_write; ed = cpu_data_write; end
        2:       begin ea = dma_address; er = dma_read_write; ed = dma_data_write; end
        default: begin ea = 16'h0000;    er = 1'b1;           ed = 8'h00;          end
      endcase
      check("cpu_grant",      32'(cpu_grant),             32'(owner == 1));
      check("dma_grant",      32'(dma_grant),             32'(owner == 2));
      check("grant_excl",     32'(cpu_grant & dma_grant), 32'h0);
      check("mem_address",    32'(mem_address),           32'(ea));
      check("mem_read_write", 32'(mem_read_write),        32'(er));
      check("mem_data_write", 32'(mem_data_write),        32'(ed));
      check("data_read",      32'(data_read),             32'(mem_data_read));
    end
  end

  initial begin
    int n;
    int mism;
    bit exp_cpu;

    // reset held two edges with both requests high
    rst = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_cpu_grant", 32'(cpu_grant),      32'h0);
    check("rst_dma_grant", 32'(dma_grant),      32'h0);
    check("rst_mem_addr",  32'(mem_address),    32'h0000);
    check("rst_mem_rw",    32'(mem_read_write), 32'h1);
    check("rst_mem_wdata", 32'(mem_data_write), 32'h00);
    check("rst_data_read", 32'(data_read),      32'h5A);
    rst = 1'b0;
    #2;
    check("release_grants", 32'({cpu_grant, dma_grant}), 32'h0);
    tick();
    check("release_next_cpu_grant", 32'(cpu_grant), 32'h1);

    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
    check("idle_grants", 32'({cpu_grant, dma_grant}), 32'h0);

    // simultaneous request from IDLE: CPU wins
    cpu_req = 1'b1; dma_req = 1'b1; cpu_address = 16'h1234; cpu_read_write = 1'b1;
    tick();
    check("tie_cpu_grant", 32'(cpu_grant),   32'h1);
    check("tie_dma_grant", 32'(dma_grant),   32'h0);
    check("tie_mem_addr",  32'(mem_address), 32'h1234);
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // DMA burst interrupted by CPU request on DMA cycle 3
    dma_req = 1'b1; dma_address = 16'h0200; dma_read_write = 1'b0; dma_data_write = 8'hAA;
    cpu_address = 16'h4321;
    tick();
    check("dma_mem_addr",  32'(mem_address),    32'h0200);
    check("dma_mem_wdata", 32'(mem_data_write), 32'hAA);
    check("dma_mem_rw",    32'(mem_read_write), 32'h0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (!dma_grant) break;
      n++;
      if (n == 3) cpu_req = 1'b1;
      tick();
    end
    check("burst_len",          32'(n),           32'd8);
    check("burst_end_cpu",      32'(cpu_grant),   32'h1);
    check("burst_end_mem_addr", 32'(mem_address), 32'h4321);
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // DMA alone: no forced yield, counter saturates
    dma_req = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (dma_grant) n++;
      if (i < 19) tick();
    end
    check("dma_alone_cycles", 32'(n),           32'd20);
    check("burst_saturate",   32'(dut.burst_q), 32'd8);
    dma_req = 1'b0;
    tick();

    // both requests held high
    cpu_req = 1'b1; dma_req = 1'b1;
    tick();
    mism = 0;
    for (int i = 0; i < 36; i++) begin
      exp_cpu = FAIR ? ((i % 12) < 4) : 1'b1;
      if (cpu_grant !== exp_cpu || dma_grant !== !exp_cpu) mism++;
      tick();
    end
    check("grant_pattern", 32'(mism), 32'h0);
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 5) == 0) cpu_req = ~cpu_req;
      if ($urandom_range(0, 7) == 0) dma_req = ~dma_req;
      cpu_address    = 16'($urandom);
      cpu_read_write = 1'($urandom);
      cpu_data_write = 8'($urandom);
      dma_address    = 16'($urandom);
      dma_read_write = 1'($urandom);
      dma_data_write = 8'($urandom);
      mem_data_read  = 8'($urandom);
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
